// File: rtl/pix_link_pkg.sv
// Shared definitions for both ends of the 12-bit pixel-over-UART link:
// sender FSM encodings, pixel payload layout and the check-code bit select.
package pix_link_pkg;

    localparam int unsigned PIX_W          = 12;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned STATE_W        = 4;
    localparam int unsigned FRAME_PIX_DEF  = 76800;
    localparam logic [3:0]  PAD_NIBBLE_DEF = 4'h0;

    localparam logic [STATE_W-1:0] ST_IDLE     = 4'b0001;
    localparam logic [STATE_W-1:0] ST_SEND_HI  = 4'b0010;
    localparam logic [STATE_W-1:0] ST_SEND_LO  = 4'b0100;
    localparam logic [STATE_W-1:0] ST_SEND_CHK = 4'b1000;

    typedef enum logic [STATE_W-1:0] {
        SND_IDLE = ST_IDLE,
        SND_HI   = ST_SEND_HI,
        SND_LO   = ST_SEND_LO,
        SND_CHK  = ST_SEND_CHK
    } snd_state_t;

    // Pixel as it travels: high byte first, low nibble padded into the second byte.
    typedef struct packed {
        logic [7:0] hi;
        logic [3:0] lo;
    } pix_t;

    function automatic logic [BYTE_W-1:0] check_code_f(input logic [BYTE_W-1:0] b1,
                                                       input logic [BYTE_W-1:0] b2);
        return {b1[7], b1[4], b1[3], b1[0], b2[7], b2[4], b2[3], b2[0]};
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous pixel FIFO with registered read data and full/empty flags.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module pix_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + (AW+1)'(1);
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/pix_tx_pack.sv
// Pixel-over-UART transmit packer: buffers 12-bit pixels and sends each as byte1/byte2.
// Build option PIX_TX_CHECK_EN appends the check code as a third byte per pixel.
module pix_tx_pack
    import pix_link_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_PIX  = FRAME_PIX_DEF,
    parameter int unsigned CNT_W      = 17,
    parameter logic [3:0]  PAD_NIBBLE = PAD_NIBBLE_DEF
) (
    input  logic                 i_clk_sys,
    input  logic                 i_rst_n,
    input  logic [PIX_W-1:0]     i_pix,
    input  logic                 i_pix_valid,
    output logic                 o_pix_ready,
    input  logic                 i_image_sending,
    output logic [BYTE_W-1:0]    o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_busy,
    output logic [STATE_W-1:0]   o_snd_state,
    output logic [BYTE_W-1:0]    o_check_code,
    output logic                 o_check_valid,
    output logic [CNT_W-1:0]     o_pix_count,
    output logic                 o_frame_done
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);

    snd_state_t        state;
    logic              wait_ph;
    logic              skip_ph;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [PIX_W-1:0]  fifo_dout;
    pix_t              hold;
    logic [BYTE_W-1:0] byte_hi;
    logic [BYTE_W-1:0] byte_lo;
    logic [BYTE_W-1:0] cur_byte;
    logic              is_send;
    logic              last_byte;

    assign push        = i_pix_valid && !fifo_full;
    assign pop         = (state == SND_IDLE) && i_image_sending && !fifo_empty;
    assign o_pix_ready = !fifo_full;
    assign o_snd_state = state;

    // The FIFO's registered read port doubles as the pixel holding register;
    // it only changes on a pop, which happens only in IDLE.
    assign hold    = pix_t'(fifo_dout);
    assign byte_hi = hold.hi;
    assign byte_lo = {hold.lo, PAD_NIBBLE};

    pix_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk_sys),
        .rst_n   (i_rst_n),
        .wr_en   (push),
        .wr_data (i_pix),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Byte select for the current send state and end-of-pixel decode.
    always_comb begin
        cur_byte  = byte_hi;
        is_send   = 1'b0;
        last_byte = 1'b0;
        case (state)
            SND_HI: begin
                cur_byte = byte_hi;
                is_send  = 1'b1;
            end
            SND_LO: begin
                cur_byte = byte_lo;
                is_send  = 1'b1;
`ifndef PIX_TX_CHECK_EN
                last_byte = 1'b1;
`endif
            end
`ifdef PIX_TX_CHECK_EN
            SND_CHK: begin
                cur_byte  = o_check_code;
                is_send   = 1'b1;
                last_byte = 1'b1;
            end
`endif
            default: begin
                cur_byte = byte_hi;
            end
        endcase
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= SND_IDLE;
            wait_ph       <= 1'b0;
            skip_ph       <= 1'b0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
            o_check_code  <= '0;
            o_check_valid <= 1'b0;
            o_pix_count   <= '0;
            o_frame_done  <= 1'b0;
        end else begin
            o_tx_start    <= 1'b0;
            o_check_valid <= 1'b0;
            o_frame_done  <= 1'b0;
            case (state)
                SND_IDLE: begin
                    wait_ph <= 1'b0;
                    skip_ph <= 1'b0;
                    if (pop) begin
                        state <= SND_HI;
                    end
                end
                default: begin
                    if (!is_send) begin
                        state <= SND_IDLE;
                    end else if (!wait_ph) begin
                        if (!i_tx_busy) begin
                            o_tx_data  <= cur_byte;
                            o_tx_start <= 1'b1;
                            wait_ph    <= 1'b1;
                            skip_ph    <= 1'b1;
                            if (state == SND_LO) begin
                                o_check_code  <= check_code_f(byte_hi, byte_lo);
                                o_check_valid <= 1'b1;
                            end
                        end
                    end else if (skip_ph) begin
                        // UART busy only rises the cycle after it sees the start pulse.
                        skip_ph <= 1'b0;
                    end else if (!i_tx_busy) begin
                        wait_ph <= 1'b0;
                        if (last_byte) begin
                            state <= SND_IDLE;
                            if (o_pix_count == LAST_PIX) begin
                                o_pix_count  <= '0;
                                o_frame_done <= 1'b1;
                            end else begin
                                o_pix_count <= o_pix_count + CNT_W'(1);
                            end
                        end else if (state == SND_HI) begin
                            state <= SND_LO;
                        end
`ifdef PIX_TX_CHECK_EN
                        else begin
                            state <= SND_CHK;
                        end
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pix_tx_pack.sv
// Self-checking bench for pix_tx_pack: UART busy model, byte-stream and check-code
// reference model derived directly from pixel bit positions.
module tb_pix_tx_pack;

    localparam int unsigned FRAME = 4;
    localparam int unsigned DEPTH = 16;
`ifdef PIX_TX_CHECK_EN
    localparam int BPP = 3;
`else
    localparam int BPP = 2;
`endif
    localparam logic [3:0]  PAD    = 4'h0;
    localparam logic [3:0]  S_IDLE = 4'b0001;
    localparam logic [3:0]  S_HI   = 4'b0010;
    localparam logic [22:0] RST_VEC = {8'h00, 1'b0, 4'b0001, 8'h00, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] pix = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        image_sending = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [3:0]  snd_state;
    logic [7:0]  check_code;
    logic        check_valid;
    logic [16:0] pix_count;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] cc_q[$];
    logic [7:0] exp_cc_q[$];
    int cmp_ptr = 0;
    int cc_ptr = 0;
    int busy_cnt = 0;
    int busy_len = 10;
    bit busy_rand = 1'b0;
    bit force_busy = 1'b0;
    int n_start = 0;
    int fd_cnt = 0;
    int proto_err = 0;
    int px_since_rst = 0;
    int fd_base = 0;

    pix_tx_pack #(
        .FIFO_DEPTH (DEPTH),
        .FRAME_PIX  (FRAME),
        .CNT_W      (17),
        .PAD_NIBBLE (PAD)
    ) dut (
        .i_clk_sys       (clk),
        .i_rst_n         (rst_n),
        .i_pix           (pix),
        .i_pix_valid     (pix_valid),
        .o_pix_ready     (pix_ready),
        .i_image_sending (image_sending),
        .o_tx_data       (tx_data),
        .o_tx_start      (tx_start),
        .i_tx_busy       (tx_busy),
        .o_snd_state     (snd_state),
        .o_check_code    (check_code),
        .o_check_valid   (check_valid),
        .o_pix_count     (pix_count),
        .o_frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    assign tx_busy = (busy_cnt != 0) || force_busy;

    // UART TX model and output monitor; the UART is never reset by the DUT.
    always @(posedge clk) begin
        if (tx_start) begin
            got_q.push_back(tx_data);
            n_start++;
            if (tx_busy) proto_err++;
            busy_cnt <= busy_rand ? 1 + int'($urandom_range(7)) : busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (check_valid) begin
            cc_q.push_back(check_code);
            if (!tx_start) proto_err++;
        end
        if (frame_done) fd_cnt++;
    end

    // Reference: byte stream and check code straight from the pixel's bit positions.
    task automatic model_push(input logic [11:0] p);
        logic [7:0] code;
        code = {p[11], p[8], p[7], p[4], p[3], p[0], PAD[3], PAD[0]};
        exp_q.push_back(p[11:4]);
        exp_q.push_back({p[3:0], PAD});
        exp_cc_q.push_back(code);
        if (BPP == 3) exp_q.push_back(code);
        px_since_rst++;
    endtask

    task automatic push_pix(input logic [11:0] p, output bit acc);
        @(negedge clk);
        pix = p;
        pix_valid = 1'b1;
        acc = pix_ready;
        if (acc) model_push(p);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (got_q.size() >= n && snd_state == S_IDLE && busy_cnt == 0 && !force_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        px_since_rst = 0;
        fd_base = fd_cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_data, tx_start, snd_state, check_code, check_valid, frame_done} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", {tx_data, tx_start, snd_state, check_code, check_valid, frame_done}, RST_VEC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_count !== 17'd0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_count_ready got=%0d/%b exp=0/1", pix_count, pix_ready);
        end
    endtask

    task automatic test_single();
        bit acc;
        bit ok;
        image_sending = 1'b1;
        push_pix(12'hABC, acc);
        wait_idle(exp_q.size(), ok);
        checks++;
        if (!acc || !ok) begin
            errors++;
            $display("FAIL single_done got acc=%b idle=%b exp 1/1", acc, ok);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_nbytes got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = cmp_ptr; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        cmp_ptr = exp_q.size();
        checks++;
        if (cc_q.size() != exp_cc_q.size()) begin
            errors++;
            $display("FAIL single_ccount got=%0d exp=%0d", cc_q.size(), exp_cc_q.size());
        end
        for (int i = cc_ptr; i < exp_cc_q.size() && i < cc_q.size(); i++) begin
            checks++;
            if (cc_q[i] !== exp_cc_q[i]) begin
                errors++;
                $display("FAIL single_code[%0d] got=%h exp=%h", i, cc_q[i], exp_cc_q[i]);
            end
        end
        cc_ptr = exp_cc_q.size();
    endtask

    task automatic test_fifo_full();
        bit acc;
        bit ok;
        image_sending = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_pix(12'($urandom), acc);
            checks++;
            if (acc !== (i < DEPTH)) begin
                errors++;
                $display("FAIL full_ready[%0d] got=%b exp=%b", i, acc, (i < DEPTH));
            end
        end
        image_sending = 1'b1;
        wait_idle(exp_q.size(), ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL full_drain got=%0d bytes idle=%b exp=%0d", got_q.size(), ok, exp_q.size());
        end
        for (int i = cmp_ptr; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        cmp_ptr = exp_q.size();
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_after got=%b exp=1", pix_ready);
        end
    endtask

    task automatic test_busy_hold();
        bit acc;
        bit ok;
        int n0;
        force_busy = 1'b1;
        image_sending = 1'b1;
        n0 = n_start;
        push_pix(12'($urandom), acc);
        repeat (50) @(negedge clk);
        checks++;
        if (n_start != n0) begin
            errors++;
            $display("FAIL busy_nostart got=%0d exp=%0d", n_start, n0);
        end
        checks++;
        if (snd_state !== S_HI) begin
            errors++;
            $display("FAIL busy_state got=%b exp=%b", snd_state, S_HI);
        end
        force_busy = 1'b0;
        wait_idle(exp_q.size(), ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL busy_drain got=%0d idle=%b exp=%0d", got_q.size(), ok, exp_q.size());
        end
        for (int i = cmp_ptr; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL busy_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        cmp_ptr = exp_q.size();
    endtask

    task automatic test_random();
        bit ok;
        busy_rand = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            pix = 12'($urandom);
            pix_valid = 1'($urandom_range(1));
            if (pix_valid && pix_ready) model_push(pix);
            image_sending = ($urandom_range(7) != 0);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        image_sending = 1'b1;
        wait_idle(exp_q.size(), ok);
        busy_rand = 1'b0;
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_drain got=%0d idle=%b exp=%0d", got_q.size(), ok, exp_q.size());
        end
        for (int i = cmp_ptr; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        cmp_ptr = exp_q.size();
        checks++;
        if (cc_q.size() != exp_cc_q.size()) begin
            errors++;
            $display("FAIL rand_ccount got=%0d exp=%0d", cc_q.size(), exp_cc_q.size());
        end
        for (int i = cc_ptr; i < exp_cc_q.size() && i < cc_q.size(); i++) begin
            checks++;
            if (cc_q[i] !== exp_cc_q[i]) begin
                errors++;
                $display("FAIL rand_code[%0d] got=%h exp=%h", i, cc_q[i], exp_cc_q[i]);
            end
        end
        cc_ptr = exp_cc_q.size();
        checks++;
        if (pix_count !== 17'(px_since_rst % FRAME) || (fd_cnt - fd_base) != px_since_rst / FRAME) begin
            errors++;
            $display("FAIL rand_frame got=%0d/%0d exp=%0d/%0d", pix_count, fd_cnt - fd_base, px_since_rst % FRAME, px_since_rst / FRAME);
        end
    endtask

    task automatic test_frame();
        bit acc;
        bit ok;
        do_reset();
        image_sending = 1'b1;
        for (int i = 0; i < 5; i++) push_pix(12'($urandom), acc);
        wait_idle(exp_q.size(), ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL frame_drain got=%0d idle=%b exp=%0d", got_q.size(), ok, exp_q.size());
        end
        for (int i = cmp_ptr; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL frame_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        cmp_ptr = exp_q.size();
        checks++;
        if ((fd_cnt - fd_base) != px_since_rst / FRAME) begin
            errors++;
            $display("FAIL frame_done_count got=%0d exp=%0d", fd_cnt - fd_base, px_since_rst / FRAME);
        end
        checks++;
        if (pix_count !== 17'(px_since_rst % FRAME)) begin
            errors++;
            $display("FAIL frame_pix_count got=%0d exp=%0d", pix_count, px_since_rst % FRAME);
        end
    endtask

    task automatic test_stop_and_reset();
        bit acc;
        bit ok;
        int base;
        image_sending = 1'b0;
        for (int i = 0; i < 3; i++) push_pix(12'($urandom), acc);
        base = got_q.size();
        image_sending = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (got_q.size() > base);
        end
        image_sending = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stop_first_byte got=timeout exp=start");
        end
        wait_idle(base + BPP, ok);
        repeat (40) @(negedge clk);
        checks++;
        if (!ok || got_q.size() != base + BPP || snd_state !== S_IDLE) begin
            errors++;
            $display("FAIL stop_one_pixel got=%0d bytes state=%b exp=%0d/%b", got_q.size() - base, snd_state, BPP, S_IDLE);
        end
        image_sending = 1'b1;
        wait_idle(exp_q.size(), ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stop_resume got=%0d idle=%b exp=%0d", got_q.size(), ok, exp_q.size());
        end
        for (int i = cmp_ptr; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stop_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        cmp_ptr = exp_q.size();

        // Reset while the first byte of a pixel is still in flight.
        base = got_q.size();
        push_pix(12'($urandom), acc);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (got_q.size() > base);
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {tx_data, tx_start, snd_state, check_code, check_valid, frame_done} !== RST_VEC) begin
            errors++;
            $display("FAIL midwait_reset got=%h started=%b exp=%h", {tx_data, tx_start, snd_state, check_code, check_valid, frame_done}, ok, RST_VEC);
        end
        checks++;
        if (pix_count !== 17'd0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL midwait_count_ready got=%0d/%b exp=0/1", pix_count, pix_ready);
        end
        for (int i = 1; i < BPP; i++) void'(exp_q.pop_back());
        void'(exp_cc_q.pop_back());
        px_since_rst = 0;
        fd_base = fd_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size() || snd_state !== S_IDLE) begin
            errors++;
            $display("FAIL after_reset got=%0d bytes state=%b exp=%0d/%b", got_q.size(), snd_state, exp_q.size(), S_IDLE);
        end
        for (int i = cmp_ptr; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        cmp_ptr = exp_q.size();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_busy_hold();
        test_random();
        test_frame();
        test_stop_and_reset();
        checks++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL handshake_protocol got=%0d violations exp=0", proto_err);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
